// File: rtl/trace_line_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : trace_line_streamer
//  Description : Drain end of the packed line-trace buffer. Captures one
//                buffer (chars from byte NCHARS-1 downward, signed free-slot
//                index in bits [31:0]) and streams it one byte per valid/ready
//                handshake, followed by a terminator byte. Counts completed
//                lines and flags out-of-range indices (sticky).
//                Optional build macro TRACE_LINE_STREAMER_PREFIX_EN adds a
//                "NNNN: " line-number prefix driven by a 4-digit BCD counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module trace_line_streamer #(
    parameter int         NCHARS    = 512,
    parameter logic [7:0] TERM_CHAR = 8'h0A
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  buf_val,
    output logic                  buf_rdy,
    input  logic [NCHARS*8-1:0]   buf_data,
    output logic                  out_val,
    input  logic                  out_rdy,
    output logic [7:0]            out_msg,
    output logic [15:0]           lines,
    output logic                  idx_err
);

    localparam int C_PTR_W = $clog2(NCHARS);
    localparam int C_MAX   = NCHARS - 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
`ifdef TRACE_LINE_STREAMER_PREFIX_EN
        S_PREFIX = 2'd1,
`endif
        S_CHARS  = 2'd2,
        S_TERM   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [7:0]           r_buf [NCHARS];
    logic [C_PTR_W-1:0]   r_ptr;
    logic [C_PTR_W-1:0]   r_end;
    logic [C_PTR_W-1:0]   w_ptr_dec;
    logic [15:0]          r_lines;
    logic                 r_idx_err;

    logic signed [31:0]   w_idx;
    logic                 w_idx_low;
    logic                 w_idx_high;
    logic [C_PTR_W-1:0]   w_end_load;

    logic                 w_load;
    logic                 w_char_adv;
    logic                 w_line_done;

`ifdef TRACE_LINE_STREAMER_PREFIX_EN
    logic [2:0]           r_pcnt;
    logic [15:0]          r_bcd;
    logic [7:0]           w_pfx_byte;
    logic                 w_pfx_adv;

    // Decimal increment of the 4-digit BCD line number, wrapping 9999 -> 0
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (carry) begin
                if (r[k*4 +: 4] == 4'd9) begin
                    r[k*4 +: 4] = 4'd0;
                end else begin
                    r[k*4 +: 4] = r[k*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction
`endif

    assign lines     = r_lines;
    assign idx_err   = r_idx_err;
    assign w_ptr_dec = r_ptr - C_PTR_W'(1);

    // Clamp the incoming signed free-slot index into the legal end range
    always_comb begin
        w_idx      = $signed(buf_data[31:0]);
        w_idx_low  = (w_idx < 3);
        w_idx_high = (w_idx > C_MAX);
        w_end_load = w_idx[C_PTR_W-1:0];
        if (w_idx_low) begin
            w_end_load = C_PTR_W'(3);
        end else if (w_idx_high) begin
            w_end_load = C_PTR_W'(C_MAX);
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and output decode from registered state and pointer
    always_comb begin
        w_state_nxt = r_state;
        buf_rdy     = 1'b0;
        out_val     = 1'b0;
        out_msg     = 8'h00;
        w_load      = 1'b0;
        w_char_adv  = 1'b0;
        w_line_done = 1'b0;
`ifdef TRACE_LINE_STREAMER_PREFIX_EN
        w_pfx_adv   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                buf_rdy = 1'b1;
                if (buf_val) begin
                    w_load = 1'b1;
`ifdef TRACE_LINE_STREAMER_PREFIX_EN
                    w_state_nxt = S_PREFIX;
`else
                    // ptr starts at the top byte, so chars exist unless end is the top byte
                    w_state_nxt = (w_end_load != C_PTR_W'(C_MAX)) ? S_CHARS : S_TERM;
`endif
                end
            end
`ifdef TRACE_LINE_STREAMER_PREFIX_EN
            S_PREFIX: begin
                out_val = 1'b1;
                out_msg = w_pfx_byte;
                if (out_rdy) begin
                    w_pfx_adv = 1'b1;
                    if (r_pcnt == 3'd5) begin
                        w_state_nxt = (r_ptr > r_end) ? S_CHARS : S_TERM;
                    end
                end
            end
`endif
            S_CHARS: begin
                out_val = 1'b1;
                out_msg = r_buf[r_ptr];
                if (out_rdy) begin
                    w_char_adv = 1'b1;
                    if (w_ptr_dec == r_end) begin
                        w_state_nxt = S_TERM;
                    end
                end
            end
            S_TERM: begin
                out_val = 1'b1;
                out_msg = TERM_CHAR;
                if (out_rdy) begin
                    w_line_done = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Buffer capture, read pointer, line counter and sticky index error
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr     <= C_PTR_W'(C_MAX);
            r_end     <= C_PTR_W'(C_MAX);
            r_lines   <= 16'd0;
            r_idx_err <= 1'b0;
            for (int i = 0; i < NCHARS; i++) begin
                r_buf[i] <= 8'h00;
            end
        end else begin
            if (w_load) begin
                for (int i = 0; i < NCHARS; i++) begin
                    r_buf[i] <= buf_data[i*8 +: 8];
                end
                r_ptr <= C_PTR_W'(C_MAX);
                r_end <= w_end_load;
                if (w_idx_low || w_idx_high) begin
                    r_idx_err <= 1'b1;
                end
            end
            if (w_char_adv) begin
                r_ptr <= w_ptr_dec;
            end
            if (w_line_done) begin
                r_lines <= r_lines + 16'd1;
            end
        end
    end

`ifdef TRACE_LINE_STREAMER_PREFIX_EN
    // Prefix byte select: leading-zero digits blank to spaces, units always shown
    always_comb begin
        w_pfx_byte = 8'h20;
        case (r_pcnt)
            3'd0:    w_pfx_byte = (r_bcd[15:12] == 4'd0) ? 8'h20 : {4'h3, r_bcd[15:12]};
            3'd1:    w_pfx_byte = (r_bcd[15:8]  == 8'd0) ? 8'h20 : {4'h3, r_bcd[11:8]};
            3'd2:    w_pfx_byte = (r_bcd[15:4] == 12'd0) ? 8'h20 : {4'h3, r_bcd[7:4]};
            3'd3:    w_pfx_byte = {4'h3, r_bcd[3:0]};
            3'd4:    w_pfx_byte = 8'h3A;
            default: w_pfx_byte = 8'h20;
        endcase
    end

    // Prefix position counter and BCD line number tracking completed lines
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pcnt <= 3'd0;
            r_bcd  <= 16'h0000;
        end else begin
            if (w_load) begin
                r_pcnt <= 3'd0;
            end else if (w_pfx_adv) begin
                r_pcnt <= r_pcnt + 3'd1;
            end
            if (w_line_done) begin
                r_bcd <= bcd_inc(r_bcd);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_trace_line_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trace_line_streamer
//  Description : Self-checking bench for trace_line_streamer. Table-driven
//                line loads with a byte scoreboard, plus hand sequences for
//                latency, mid-line reset and the prefix build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_trace_line_streamer;

    localparam int NCHARS = 512;
    localparam int W      = NCHARS * 8;
`ifdef TRACE_LINE_STREAMER_PREFIX_EN
    localparam int PFX = 6;
`else
    localparam int PFX = 0;
`endif

    logic          clk      = 1'b0;
    logic          reset    = 1'b0;
    logic          buf_val  = 1'b0;
    logic          out_rdy  = 1'b0;
    logic [W-1:0]  buf_data = '0;
    logic          buf_rdy;
    logic          out_val;
    logic [7:0]    out_msg;
    logic [15:0]   lines;
    logic          idx_err;

    trace_line_streamer #(.NCHARS(NCHARS), .TERM_CHAR(8'h0A)) dut (
        .clk      (clk),
        .reset    (reset),
        .buf_val  (buf_val),
        .buf_rdy  (buf_rdy),
        .buf_data (buf_data),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_msg  (out_msg),
        .lines    (lines),
        .idx_err  (idx_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        bit         last;
    } exp_t;

    typedef struct {
        int idx;
        int seed;
        int mode;
        bit exp_err;
        int exp_len;
    } vec_t;

    exp_t exp_q[$];
    int   n_chk    = 0;
    int   n_fail   = 0;
    int   m_num    = 0;
    int   l_issued = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: expected byte stream for one accepted buffer
    task automatic push_line(input logic [W-1:0] d);
        int    idx;
        int    e;
        string s;
        exp_t  t;
        idx = $signed(d[31:0]);
        if (idx < 3)                e = 3;
        else if (idx > NCHARS - 1)  e = NCHARS - 1;
        else                        e = idx;
        if (PFX != 0) begin
            s = $sformatf("%4d: ", m_num % 10000);
            for (int i = 0; i < 6; i++) begin
                t.b = s[i]; t.last = 1'b0;
                exp_q.push_back(t);
            end
        end
        m_num = (m_num + 1) % 10000;
        for (int p = NCHARS - 1; p > e; p--) begin
            t.b = d[p*8 +: 8]; t.last = 1'b0;
            exp_q.push_back(t);
        end
        t.b = 8'h0A; t.last = 1'b1;
        exp_q.push_back(t);
    endtask

    // One clock: score the handshakes about to happen, then advance past the edge
    task automatic tick();
        if (buf_val && buf_rdy) push_line(buf_data);
        if (out_val) begin
            if (exp_q.size() == 0) begin
                chk("out_unexpected", {24'h0, out_msg}, 32'hFFFF_FFFF);
            end else begin
                chk("out_msg", {24'h0, out_msg}, {24'h0, exp_q[0].b});
                if (out_rdy) void'(exp_q.pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy_pat(input int mode, input int cyc);
        if (mode == 0)      return 1'b1;
        else if (mode == 1) return (cyc % 3) == 0;
        else                return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_line(input logic [W-1:0] bd, input int mode, output int cyc);
        buf_data = bd;
        buf_val  = 1'b1;
        out_rdy  = rdy_pat(mode, 0);
        tick();
        buf_val  = 1'b0;
        cyc      = 1;
        while (!buf_rdy && cyc < 5000) begin
            out_rdy = rdy_pat(mode, cyc);
            tick();
            cyc++;
        end
        l_issued++;
        chk("line_done", {31'h0, buf_rdy}, 32'h1);
    endtask

    function automatic logic [W-1:0] make_buf(input int idx, input int seed);
        logic [W-1:0] bd;
        bd = '0;
        for (int p = 4; p < NCHARS; p++) bd[p*8 +: 8] = 8'(p * seed + 11);
        bd[31:0] = 32'(idx);
        return bd;
    endfunction

    vec_t         vt [10];
    logic [W-1:0] bd;
    logic [7:0]   abc_exp [4];
    int           cyc;

    initial begin
        vt[0] = '{508,  3, 0, 1'b0,   3};
        vt[1] = '{508,  5, 1, 1'b0,   3};
        vt[2] = '{511,  7, 0, 1'b0,   0};
        vt[3] = '{300,  9, 2, 1'b0, 211};
        vt[4] = '{3,   37, 0, 1'b0, 508};
        vt[5] = '{510,  1, 1, 1'b0,   1};
        vt[6] = '{600,  3, 0, 1'b1,   0};
        vt[7] = '{0,   37, 1, 1'b1, 508};
        vt[8] = '{-5,  11, 2, 1'b1, 508};
        vt[9] = '{2,   13, 0, 1'b1, 508};
        abc_exp[0] = 8'h61; abc_exp[1] = 8'h62; abc_exp[2] = 8'h63; abc_exp[3] = 8'h0A;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_buf_rdy", {31'h0, buf_rdy}, 32'h1);
        chk("rst_out_val", {31'h0, out_val}, 32'h0);
        chk("rst_out_msg", {24'h0, out_msg}, 32'h0);
        chk("rst_lines",   {16'h0, lines},   32'h0);
        chk("rst_idx_err", {31'h0, idx_err}, 32'h0);
        reset = 1'b1;
        tick();

        // Table-driven loads
        for (int v = 0; v < 10; v++) begin
            run_line(make_buf(vt[v].idx, vt[v].seed), vt[v].mode, cyc);
            if (vt[v].mode == 0) chk("line_cycles", cyc, vt[v].exp_len + 2 + PFX);
            chk("idx_err",   {31'h0, idx_err}, {31'h0, vt[v].exp_err});
            chk("lines",     {16'h0, lines},   l_issued);
            chk("q_drained", exp_q.size(),     0);
        end

        // Twelve single-char lines
        for (int n = 0; n < 12; n++) begin
            bd = '0;
            bd[(NCHARS-1)*8 +: 8] = 8'h78;
            bd[31:0] = 32'd510;
            run_line(bd, 0, cyc);
            chk("x_cycles", cyc, 3 + PFX);
        end
        chk("x_lines",   {16'h0, lines}, l_issued);
        chk("x_drained", exp_q.size(),   0);

        // Mid-line reset drops out_val immediately, clears counters
        buf_data = make_buf(0, 3);
        buf_val  = 1'b1;
        tick();
        buf_val  = 1'b0;
        out_rdy  = 1'b1;
        tick();
        tick();
        chk("mid_out_val_pre", {31'h0, out_val}, 32'h1);
        reset = 1'b0;
        #1;
        chk("mid_out_val", {31'h0, out_val}, 32'h0);
        chk("mid_buf_rdy", {31'h0, buf_rdy}, 32'h1);
        chk("mid_lines",   {16'h0, lines},   32'h0);
        chk("mid_idx_err", {31'h0, idx_err}, 32'h0);
        chk("mid_out_msg", {24'h0, out_msg}, 32'h0);
        exp_q.delete();
        m_num    = 0;
        l_issued = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();

        // "abc" latency: bytes on the cycles right after accept, idle after terminator
        bd = '0;
        bd[511*8 +: 8] = 8'h61;
        bd[510*8 +: 8] = 8'h62;
        bd[509*8 +: 8] = 8'h63;
        bd[31:0] = 32'd508;
        buf_data = bd;
        buf_val  = 1'b1;
        out_rdy  = 1'b1;
        chk("abc_rdy_pre", {31'h0, buf_rdy}, 32'h1);
        tick();
        buf_val = 1'b0;
        for (int k = 0; k < PFX + 4; k++) begin
            chk("abc_val",  {31'h0, out_val}, 32'h1);
            chk("abc_busy", {31'h0, buf_rdy}, 32'h0);
            if (k >= PFX) chk("abc_msg", {24'h0, out_msg}, {24'h0, abc_exp[k-PFX]});
            tick();
        end
        chk("abc_idle",    {31'h0, buf_rdy}, 32'h1);
        chk("abc_out_val", {31'h0, out_val}, 32'h0);
        chk("abc_lines",   {16'h0, lines},   32'h1);
        chk("abc_drained", exp_q.size(),     0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
